mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and a word-wide data memory.
// Extracts and extends sub-word loads and performs read-modify-write for
// byte/halfword stores. Misaligned or malformed requests raise misalign_err.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_*                 request from EX/MEM (valid, read, write, size,
//                         unsigned, byte address, right-aligned store data)
//   mem_address           word-aligned memory address (combinational)
//   mem_write_data        store word to memory (combinational)
//   mem_read, mem_write   memory strobes (combinational)
//   mem_read_data         combinational memory read data
//   stall                 upstream holds the request while high (combinational)
//   load_data, load_valid registered extended load result and its strobe
//   misalign_err          registered one-cycle error pulse
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SIZE_B = 2'b00;
    localparam logic [1:0]  SIZE_H = 2'b01;
    localparam logic [1:0]  SIZE_W = 2'b10;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   merge_q, merge_next;
    logic [DATA_W-1:0]   addr_q, addr_next;
    logic [DATA_W-1:0]   load_data_next;
    logic                load_valid_next;
    logic                misalign_next;

    logic                access;
    logic                err;
    logic [4:0]          lane_shift;
    logic [DATA_W-1:0]   word_addr;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   rd_shifted;
    logic [DATA_W-1:0]   load_ext;

    // Request decode, lane selection, load extension and store merge data
    always_comb begin
        access     = req_valid && (req_read || req_write);
        err        = access && ((req_size == 2'b11) ||
                                ((req_size == SIZE_H) && req_addr[0]) ||
                                ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00)) ||
                                (req_read && req_write));
        word_addr  = {req_addr[31:2], 2'b00};
        lane_shift = (req_size == SIZE_H) ? {req_addr[1], 4'b0000} : {req_addr[1:0], 3'b000};
        rd_shifted = mem_read_data >> lane_shift;
        lane_mask  = ((req_size == SIZE_H) ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
        lane_wdata = ((req_size == SIZE_H) ? DATA_W'(req_wdata[15:0])
                                           : DATA_W'(req_wdata[7:0])) << lane_shift;
        case (req_size)
            SIZE_B:  load_ext = req_unsigned ? DATA_W'(rd_shifted[7:0])
                                             : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_H:  load_ext = req_unsigned ? DATA_W'(rd_shifted[15:0])
                                             : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    // Next-state and memory-side outputs
    always_comb begin
        state_next      = state;
        merge_next      = merge_q;
        addr_next       = addr_q;
        load_data_next  = load_data;
        load_valid_next = 1'b0;
        misalign_next   = 1'b0;
        mem_address     = word_addr;
        mem_write_data  = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        stall           = 1'b0;

        case (state)
            IDLE: begin
                if (err) begin
                    misalign_next = 1'b1;
                end else if (access) begin
                    if (req_read) begin
                        mem_read        = 1'b1;
                        load_valid_next = 1'b1;
                        load_data_next  = load_ext;
                    end else if (req_size == SIZE_W) begin
                        mem_write      = 1'b1;
                        mem_write_data = req_wdata;
                    end else begin
                        // Sub-word store: read the word now, write the merge next cycle
                        mem_read   = 1'b1;
                        stall      = 1'b1;
                        merge_next = (mem_read_data & ~lane_mask) | lane_wdata;
                        addr_next  = word_addr;
                        state_next = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_address    = addr_q;
                mem_write      = 1'b1;
                mem_write_data = merge_q;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Reset suppresses any access in the same cycle, including a pending merge write
        if (reset) begin
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            stall          = 1'b0;
            mem_write_data = '0;
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            merge_q      <= '0;
            addr_q       <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            merge_q      <= merge_next;
            addr_q       <= addr_next;
            load_data    <= load_data_next;
            load_valid   <= load_valid_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [31:0] mem_address, mem_write_data, mem_read_data, load_data;
    logic        mem_read, mem_write, stall, load_valid, misalign_err;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT, and the model's own copy
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model expectations for the current cycle
    logic        e_rd = 0, e_wr = 0, e_st = 0;
    logic [31:0] e_wd = '0, e_addr = '0;
    logic        exp_lv = 0, exp_me = 0, nxt_lv = 0, nxt_me = 0;
    logic [31:0] exp_ld = '0, nxt_ld = '0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0, pend_word = '0;

    // Last driven request, re-presented while a sub-word store is in flight
    logic        r_v, r_rd, r_wr, r_un;
    logic [1:0]  r_sz;
    logic [31:0] r_a, r_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic un, input logic [1:0] off);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(off))) & 32'hFF;
            if (!un && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [31:0] wd);
        int k;
        logic [31:0] m;
        k = (sz == 2'd0) ? 8 * int'(off) : 16 * int'(off[1]);
        m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << k;
        return (w & ~m) | ((wd & ((sz == 2'd0) ? 32'hFF : 32'hFFFF)) << k);
    endfunction

    // Drive one cycle of request inputs and derive the model's expectations
    task automatic step(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] wd,
                        input logic rs);
        bit bad;
        @(posedge clk);
        #1;
        exp_lv = nxt_lv; exp_ld = nxt_ld; exp_me = nxt_me;
        reset = rs; req_valid = v; req_read = rd; req_write = wr; req_size = sz;
        req_unsigned = un; req_addr = a; req_wdata = wd;
        r_v = v; r_rd = rd; r_wr = wr; r_sz = sz; r_un = un; r_a = a; r_wd = wd;
        e_rd = 0; e_wr = 0; e_st = 0; e_wd = '0; e_addr = {a[31:2], 2'b00};
        nxt_lv = 0; nxt_me = 0; nxt_ld = exp_ld;
        if (rs) begin
            pend = 0; nxt_ld = '0;
        end else if (pend) begin
            e_wr = 1; e_wd = pend_word; e_addr = pend_addr;
            ref_mem[pend_addr[7:2]] = pend_word;
            pend = 0;
        end else if (v && (rd || wr)) begin
            bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (rd && wr);
            if (bad) begin
                nxt_me = 1;
            end else if (rd) begin
                e_rd = 1; nxt_lv = 1;
                nxt_ld = model_load(ref_mem[a[7:2]], sz, un, a[1:0]);
            end else if (sz == 2'd2) begin
                e_wr = 1; e_wd = wd; ref_mem[a[7:2]] = wd;
            end else begin
                e_rd = 1; e_st = 1; pend = 1; pend_addr = {a[31:2], 2'b00};
                pend_word = model_merge(ref_mem[a[7:2]], sz, a[1:0], wd);
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0);
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            chk("mem_write", 32'(mem_write), 32'(e_wr));
            chk("stall", 32'(stall), 32'(e_st));
            chk("mem_write_data", mem_write_data, e_wd);
            if (e_rd || e_wr) chk("mem_address", mem_address, e_addr);
            chk("load_valid", 32'(load_valid), 32'(exp_lv));
            chk("misalign_err", 32'(misalign_err), 32'(exp_me));
            chk("load_data", load_data, exp_ld);
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
        mem[3] = 32'hCAFEF00D; ref_mem[3] = 32'hCAFEF00D;

        step(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1);
        chk_en = 1'b1;
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_load_valid", 32'(load_valid), 32'h0);
        step(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1);
        idle();

        // Byte loads
        step(1, 1, 0, 2'd0, 0, 32'h05, 32'h0, 0);
        step(1, 1, 0, 2'd0, 1, 32'h05, 32'h0, 0);
        chk("lb_signed", load_data, 32'hFFFFFFAA);
        chk("lb_valid", 32'(load_valid), 32'h1);
        idle();
        chk("lbu", load_data, 32'h000000AA);

        // Halfword loads and a misaligned halfword
        step(1, 1, 0, 2'd1, 0, 32'h06, 32'h0, 0);
        step(1, 1, 0, 2'd1, 1, 32'h06, 32'h0, 0);
        chk("lh_signed", load_data, 32'hFFFF8899);
        step(1, 1, 0, 2'd1, 0, 32'h05, 32'h0, 0);
        chk("lhu", load_data, 32'h00008899);
        chk("lh_mis_no_read", 32'(mem_read), 32'h0);
        idle();
        chk("lh_mis_err", 32'(misalign_err), 32'h1);
        chk("lh_mis_no_valid", 32'(load_valid), 32'h0);
        chk("load_data_hold", load_data, 32'h00008899);

        // Byte store read-modify-write, then read back
        step(1, 0, 1, 2'd0, 0, 32'h07, 32'h11, 0);
        chk("sb_stall", 32'(stall), 32'h1);
        step(1, 0, 1, 2'd0, 0, 32'h07, 32'h11, 0);
        chk("sb_write", 32'(mem_write), 32'h1);
        chk("sb_wdata", mem_write_data, 32'h1199AABB);
        chk("sb_addr", mem_address, 32'h04);
        chk("sb_no_stall", 32'(stall), 32'h0);
        step(1, 1, 0, 2'd2, 0, 32'h04, 32'h0, 0);
        idle();
        chk("lw_after_sb", load_data, 32'h1199AABB);

        // Word stores, aligned and misaligned
        step(1, 0, 1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 0);
        chk("sw_write", 32'(mem_write), 32'h1);
        chk("sw_wdata", mem_write_data, 32'hDEADBEEF);
        chk("sw_no_stall", 32'(stall), 32'h0);
        step(1, 0, 1, 2'd2, 0, 32'h0A, 32'h12345678, 0);
        chk("sw_mis_no_write", 32'(mem_write), 32'h0);
        idle();
        chk("sw_mis_err", 32'(misalign_err), 32'h1);

        // Halfword store aborted by reset during its write cycle
        step(1, 0, 1, 2'd1, 0, 32'h0C, 32'h1234, 0);
        step(1, 0, 1, 2'd1, 0, 32'h0C, 32'h1234, 1);
        chk("sh_rst_no_write", 32'(mem_write), 32'h0);
        chk("sh_rst_no_stall", 32'(stall), 32'h0);
        idle();
        chk("sh_rst_load_data", load_data, 32'h0);
        chk("sh_rst_word", mem[3], 32'hCAFEF00D);

        // Back-to-back traffic
        step(1, 1, 0, 2'd2, 0, 32'h04, 32'h0, 0);
        step(1, 1, 0, 2'd2, 0, 32'h08, 32'h0, 0);
        chk("b2b_lv1", 32'(load_valid), 32'h1);
        chk("b2b_ld1", load_data, 32'h1199AABB);
        step(1, 0, 1, 2'd0, 0, 32'h10, 32'h5A, 0);
        chk("b2b_lv2", 32'(load_valid), 32'h1);
        chk("b2b_ld2", load_data, 32'hDEADBEEF);
        chk("b2b_stall", 32'(stall), 32'h1);
        step(1, 0, 1, 2'd0, 0, 32'h10, 32'h5A, 0);
        chk("b2b_stall_end", 32'(stall), 32'h0);
        idle();

        // Random traffic; a stalled store is held for its second cycle
        for (int n = 0; n < 400; n++) begin
            logic rs;
            rs = ($urandom_range(0, 49) == 0);
            if (pend) begin
                step(r_v, r_rd, r_wr, r_sz, r_un, r_a, r_wd, rs);
            end else begin
                int op;
                logic [31:0] a;
                op = $urandom_range(0, 19);
                a  = $urandom;
                if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                step(op < 17, op < 8 || op == 16, op >= 8, 2'($urandom_range(0, 3)),
                     1'($urandom), a, $urandom, rs);
            end
        end
        if (pend) step(r_v, r_rd, r_wr, r_sz, r_un, r_a, r_wd, 0);
        idle();
        idle();
        chk_en = 1'b0;
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
